krake_intercon: RTL and testbench

Parametrised bus interconnect between the `krake_bus` master and up to 15 register-mapped slaves such as `krake_port` and `clk_gen`. It decodes the upper address bits into one-hot slave strobes and registers the returned read data and acknowledge. It adds features the fixed combinational decoder lacks:
- bus-error responses for unmapped slots and timeouts;
- an error counter;
- a built-in status slot.

The core top level instantiates it once.

---
 rtl/krake_intercon.sv | 149 ++++++++++++++
 tb/tb_krake_intercon.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/krake_intercon.sv
// Bus interconnect between the krake_bus master and up to 15 register-mapped slaves.
// Decodes the slot field into one-hot strobes, times out silent slaves and serves a status slot.
module krake_intercon #(
  parameter int N_SLAVES = 12,
  parameter int ADR_W    = 8,
  parameter int SEL_W    = 4,
  parameter int DAT_W    = 8,
  parameter int TIMEOUT  = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      m_stb_i,
  input  logic                      m_we_i,
  input  logic [ADR_W-1:0]          m_adr_i,
  input  logic [DAT_W-1:0]          m_dat_i,
  output logic [DAT_W-1:0]          m_dat_o,
  output logic                      m_ack_o,
  output logic                      m_err_o,
  output logic [N_SLAVES-1:0]       s_stb_o,
  output logic                      s_we_o,
  output logic [ADR_W-SEL_W-1:0]    s_adr_o,
  output logic [DAT_W-1:0]          s_dat_o,
  input  logic [N_SLAVES*DAT_W-1:0] s_dat_i,
  input  logic [N_SLAVES-1:0]       s_ack_i
);

  localparam int OFS_W = ADR_W - SEL_W;
  localparam logic [SEL_W-1:0] STATUS_SEL = '1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [OFS_W-1:0]    r_ofs;
  logic                r_we;
  logic [DAT_W-1:0]    r_wdat;
  logic [DAT_W-1:0]    r_rdat;
  logic                r_ack;
  logic                r_err;
  logic [N_SLAVES-1:0] r_stb;
  logic [7:0]          r_tcnt;
  logic [7:0]          r_err_cnt;
  logic [7:0]          r_err_adr;

  logic [SEL_W-1:0]    w_sel;
  logic [OFS_W-1:0]    w_ofs;
  logic                w_ack;
  logic [DAT_W-1:0]    w_slv_dat;
  logic [DAT_W-1:0]    w_stat_dat;

  assign w_sel = m_adr_i[ADR_W-1:OFS_W];
  assign w_ofs = m_adr_i[OFS_W-1:0];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // The strobe is one-hot, so masking with it picks only the selected slave's ack and data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_ack     = |(s_ack_i & r_stb);
    w_slv_dat = '0;
    for (int k = 0; k < N_SLAVES; k++)
      if (r_stb[k]) w_slv_dat = w_slv_dat | s_dat_i[k*DAT_W +: DAT_W];
  end

  always_comb begin
    w_stat_dat = '0;
    case (int'(w_ofs))
      0:       w_stat_dat = DAT_W'(r_err_cnt);
      1:       w_stat_dat = DAT_W'(r_err_adr);
      2:       w_stat_dat = DAT_W'(8'(N_SLAVES));
      default: w_stat_dat = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_ofs     <= '0;
      r_we      <= 1'b0;
      r_wdat    <= '0;
      r_rdat    <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_stb     <= '0;
      r_tcnt    <= '0;
      r_err_cnt <= '0;
      r_err_adr <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: if (m_stb_i) begin
          r_sel  <= w_sel;
          r_ofs  <= w_ofs;
          r_we   <= m_we_i;
          r_wdat <= m_dat_i;
          r_tcnt <= '0;
          if (int'(w_sel) < N_SLAVES) begin
            r_stb   <= N_SLAVES'(1) << w_sel;
            r_state <= S_BUSY;
          end else if (w_sel == STATUS_SEL) begin
            r_ack <= 1'b1;
            if (!m_we_i)          r_rdat    <= w_stat_dat;
            else if (w_ofs == '0) r_err_cnt <= '0;
            r_state <= S_DONE;
          end else begin
            r_err     <= 1'b1;
            r_err_cnt <= sat_inc(r_err_cnt);
            r_err_adr <= 8'(m_adr_i);
            r_state   <= S_DONE;
          end
        end
        S_BUSY: begin
          // An ack arriving in the final timeout cycle still completes normally.
          if (w_ack) begin
            r_stb   <= '0;
            r_ack   <= 1'b1;
            if (!r_we) r_rdat <= w_slv_dat;
            r_state <= S_DONE;
          end else if (r_tcnt == 8'(TIMEOUT - 1)) begin
            r_stb     <= '0;
            r_err     <= 1'b1;
            r_rdat    <= '1;
            r_err_cnt <= sat_inc(r_err_cnt);
            r_err_adr <= 8'({r_sel, r_ofs});
            r_state   <= S_DONE;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        S_DONE: if (!m_stb_i) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_dat_o = r_rdat;
  assign m_ack_o = r_ack;
  assign m_err_o = r_err;
  assign s_stb_o = r_stb;
  assign s_we_o  = r_we;
  assign s_adr_o = r_ofs;
  assign s_dat_o = r_wdat;

endmodule

// File: tb/tb_krake_intercon.sv
// Directed bench for krake_intercon: modelled slaves with programmable ack delay,
// status slot, timeout, unmapped slots, saturation and mid-transaction reset.
module tb_krake_intercon;

  localparam int N  = 12;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          m_stb_i = 1'b0;
  logic          m_we_i = 1'b0;
  logic [7:0]    m_adr_i = '0;
  logic [DW-1:0] m_dat_i = '0;
  logic [DW-1:0] m_dat_o;
  logic          m_ack_o;
  logic          m_err_o;
  logic [N-1:0]  s_stb_o;
  logic          s_we_o;
  logic [3:0]    s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [N*DW-1:0] s_dat_i;
  logic [N-1:0]  s_ack_i;

  logic [7:0]    rd_val  [N];
  logic [7:0]    ack_dly [N];
  logic [7:0]    stb_cnt [N];
  logic [N-1:0]  force_ack = '0;

  int total = 0;
  int bad   = 0;

  krake_intercon #(.N_SLAVES(N), .ADR_W(8), .SEL_W(4), .DAT_W(DW), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Slave k acks in its (ack_dly[k]+1)-th strobe cycle; 0xFF means never.
  always @(posedge clk_i)
    for (int k = 0; k < N; k++)
      stb_cnt[k] <= s_stb_o[k] ? stb_cnt[k] + 8'd1 : 8'd0;

  always_comb begin
    s_ack_i = '0;
    s_dat_i = '0;
    for (int k = 0; k < N; k++) begin
      s_ack_i[k] = force_ack[k] | (s_stb_o[k] && stb_cnt[k] == ack_dly[k]);
      s_dat_i[k*DW +: DW] = rd_val[k];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [7:0] adr, input logic we, input logic [7:0] dat);
    m_stb_i = 1'b1; m_adr_i = adr; m_we_i = we; m_dat_i = dat;
    tick;
  endtask

  task automatic release_stb;
    m_stb_i = 1'b0;
    tick;
  endtask

  task automatic status_read(input logic [7:0] adr, input logic [7:0] exp, input string name);
    drive(adr, 1'b0, 8'h00);
    total++; if (m_ack_o !== 1'b1 || m_err_o !== 1'b0) begin bad++;
      $display("FAIL %s ack/err got=%b%b exp=10", name, m_ack_o, m_err_o); end
    total++; if (m_dat_o !== exp) begin bad++;
      $display("FAIL %s data got=%h exp=%h", name, m_dat_o, exp); end
    release_stb;
  endtask

  task automatic status_write(input logic [7:0] adr, input logic [7:0] dat, input string name);
    drive(adr, 1'b1, dat);
    total++; if (m_ack_o !== 1'b1 || m_err_o !== 1'b0 || s_stb_o !== '0) begin bad++;
      $display("FAIL %s ack/err/stb got=%b%b%h exp=10000", name, m_ack_o, m_err_o, s_stb_o); end
    release_stb;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) tick;
    total++; if ({m_ack_o, m_err_o, s_stb_o, s_we_o} !== '0) begin bad++;
      $display("FAIL reset_ctrl got=%b%b%h%b exp=0", m_ack_o, m_err_o, s_stb_o, s_we_o); end
    total++; if ({m_dat_o, s_adr_o, s_dat_o} !== '0) begin bad++;
      $display("FAIL reset_data got=%h/%h/%h exp=0", m_dat_o, s_adr_o, s_dat_o); end
    rst_i = 1'b0;
    tick;
  endtask

  task automatic test_ext_read;
    rd_val[3] = 8'hA5; ack_dly[3] = 8'd0;
    drive(8'h32, 1'b0, 8'h00);
    total++; if (s_stb_o !== 12'h008 || s_adr_o !== 4'h2 || s_we_o !== 1'b0 || m_ack_o !== 1'b0) begin bad++;
      $display("FAIL rd_strobe got stb=%h adr=%h we=%b ack=%b exp stb=008 adr=2 we=0 ack=0",
               s_stb_o, s_adr_o, s_we_o, m_ack_o); end
    tick;
    total++; if (m_ack_o !== 1'b1 || m_err_o !== 1'b0 || s_stb_o !== '0) begin bad++;
      $display("FAIL rd_ack got ack=%b err=%b stb=%h exp 1 0 000", m_ack_o, m_err_o, s_stb_o); end
    total++; if (m_dat_o !== 8'hA5) begin bad++;
      $display("FAIL rd_data got=%h exp=a5", m_dat_o); end
    // Master keeps the strobe high: no second transaction may start.
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (m_ack_o !== 1'b0 || m_err_o !== 1'b0 || s_stb_o !== '0) begin bad++;
        $display("FAIL hold_stb[%0d] got ack=%b err=%b stb=%h exp 0 0 000", i, m_ack_o, m_err_o, s_stb_o); end
    end
    release_stb;
  endtask

  task automatic test_delayed_write;
    ack_dly[0] = 8'd3;
    drive(8'h07, 1'b1, 8'h5C);
    for (int i = 0; i < 4; i++) begin
      total++; if (s_stb_o !== 12'h001 || s_dat_o !== 8'h5C || s_adr_o !== 4'h7 || s_we_o !== 1'b1 || m_ack_o !== 1'b0) begin bad++;
        $display("FAIL wr_strobe[%0d] got stb=%h dat=%h adr=%h we=%b ack=%b exp 001 5c 7 1 0",
                 i, s_stb_o, s_dat_o, s_adr_o, s_we_o, m_ack_o); end
      tick;
    end
    total++; if (m_ack_o !== 1'b1 || m_err_o !== 1'b0 || s_stb_o !== '0) begin bad++;
      $display("FAIL wr_ack got ack=%b err=%b stb=%h exp 1 0 000", m_ack_o, m_err_o, s_stb_o); end
    total++; if (m_dat_o !== 8'hA5) begin bad++;
      $display("FAIL wr_keeps_data got=%h exp=a5", m_dat_o); end
    tick;
    total++; if (m_ack_o !== 1'b0) begin bad++;
      $display("FAIL wr_ack_pulse got=%b exp=0", m_ack_o); end
    release_stb;
  endtask

  task automatic test_timeout;
    int cnt = 0;
    ack_dly[5] = 8'hFF;
    drive(8'h53, 1'b0, 8'h00);
    for (int i = 0; i < 40 && !m_err_o; i++) begin
      if (s_stb_o[5]) cnt++;
      tick;
    end
    total++; if (cnt != 16) begin bad++;
      $display("FAIL to_stb_cycles got=%0d exp=16", cnt); end
    total++; if (m_err_o !== 1'b1 || m_ack_o !== 1'b0 || s_stb_o !== '0) begin bad++;
      $display("FAIL to_err got err=%b ack=%b stb=%h exp 1 0 000", m_err_o, m_ack_o, s_stb_o); end
    total++; if (m_dat_o !== 8'hFF) begin bad++;
      $display("FAIL to_data got=%h exp=ff", m_dat_o); end
    release_stb;
    force_ack[5] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (m_ack_o !== 1'b0 || m_err_o !== 1'b0) begin bad++;
        $display("FAIL late_ack[%0d] got ack=%b err=%b exp 0 0", i, m_ack_o, m_err_o); end
    end
    force_ack[5] = 1'b0;
    tick;
    status_read(8'hF0, 8'h01, "to_err_cnt");
    status_read(8'hF1, 8'h53, "to_err_adr");
  endtask

  task automatic test_unmapped_status;
    status_write(8'hF0, 8'h3E, "clr_before");
    drive(8'hC0, 1'b0, 8'h00);
    total++; if (m_err_o !== 1'b1 || m_ack_o !== 1'b0 || s_stb_o !== '0) begin bad++;
      $display("FAIL unmapped got err=%b ack=%b stb=%h exp 1 0 000", m_err_o, m_ack_o, s_stb_o); end
    tick;
    total++; if (m_err_o !== 1'b0) begin bad++;
      $display("FAIL unmapped_pulse got=%b exp=0", m_err_o); end
    release_stb;
    status_read(8'hF0, 8'h01, "um_err_cnt");
    status_read(8'hF1, 8'hC0, "um_err_adr");
    status_write(8'hF1, 8'h99, "wr_readonly");
    status_read(8'hF1, 8'hC0, "ro_unchanged");
    total++; if (m_dat_o !== 8'hC0) begin bad++;
      $display("FAIL st_wr_keeps_data got=%h exp=c0", m_dat_o); end
    status_write(8'hF0, 8'h00, "clr");
    status_read(8'hF0, 8'h00, "cleared_cnt");
    status_read(8'hF2, 8'h0C, "n_slaves");
    status_read(8'hF7, 8'h00, "unused_ofs");
  endtask

  task automatic test_saturation_collision;
    int errs = 0;
    int cnt = 0;
    for (int i = 0; i < 300; i++) begin
      drive(8'hD5, 1'b0, 8'h00);
      if (m_err_o === 1'b1) errs++;
      release_stb;
    end
    total++; if (errs != 300) begin bad++;
      $display("FAIL sat_err_pulses got=%0d exp=300", errs); end
    status_read(8'hF0, 8'hFF, "sat_cnt");
    rd_val[7] = 8'h3C; ack_dly[7] = 8'd15;
    drive(8'h71, 1'b0, 8'h00);
    for (int i = 0; i < 40 && !(m_ack_o || m_err_o); i++) begin
      if (s_stb_o[7]) cnt++;
      tick;
    end
    total++; if (cnt != 16 || m_ack_o !== 1'b1 || m_err_o !== 1'b0) begin bad++;
      $display("FAIL collision got stb_cycles=%0d ack=%b err=%b exp 16 1 0", cnt, m_ack_o, m_err_o); end
    total++; if (m_dat_o !== 8'h3C) begin bad++;
      $display("FAIL collision_data got=%h exp=3c", m_dat_o); end
    release_stb;
  endtask

  task automatic test_reset_mid;
    ack_dly[2] = 8'hFF;
    drive(8'h20, 1'b1, 8'h77);
    tick;
    total++; if (s_stb_o !== 12'h004) begin bad++;
      $display("FAIL mid_busy_stb got=%h exp=004", s_stb_o); end
    rst_i = 1'b1; m_stb_i = 1'b0;
    tick;
    total++; if ({m_ack_o, m_err_o, s_stb_o, s_we_o} !== '0 || {m_dat_o, s_adr_o, s_dat_o} !== '0) begin bad++;
      $display("FAIL mid_reset got ack=%b err=%b stb=%h we=%b dat=%h adr=%h sdat=%h exp all 0",
               m_ack_o, m_err_o, s_stb_o, s_we_o, m_dat_o, s_adr_o, s_dat_o); end
    rst_i = 1'b0;
    tick;
    drive(8'h30, 1'b0, 8'h00);
    tick;
    total++; if (m_ack_o !== 1'b1 || m_dat_o !== 8'hA5) begin bad++;
      $display("FAIL post_reset_rd got ack=%b dat=%h exp 1 a5", m_ack_o, m_dat_o); end
    release_stb;
    status_read(8'hF0, 8'h00, "post_reset_cnt");
    status_read(8'hF1, 8'h00, "post_reset_adr");
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rd_val[k]  = 8'(k * 17 + 1);
      ack_dly[k] = 8'd0;
    end
    test_reset;
    test_ext_read;
    test_delayed_write;
    test_timeout;
    test_unmapped_status;
    test_saturation_collision;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
